// File: rtl/pacing_timing_controller.sv
// Demand-pacing (VVI-style) timing sequencer: paces when no intrinsic beat arrives
// within the selected escape interval, with a refractory window after every event.
module pacing_timing_controller #(
    parameter int TICK_DIV = 1000,
    parameter int CNT_W    = 12,
    parameter int LRI_0    = 1000,
    parameter int LRI_1    = 857,
    parameter int LRI_2    = 750,
    parameter int LRI_3    = 667,
    parameter int PW_TICKS = 2,
    parameter int RP_TICKS = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sense_in,
    input  logic       enable,
    input  logic [1:0] rate_sel,
    output logic       pace_out,
    output logic       sense_evt,
    output logic [1:0] state,
    output logic [7:0] pace_cnt
);

    localparam int PRESC_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
    localparam logic [CNT_W-1:0]   PW_LAST    = CNT_W'(PW_TICKS - 1);
    localparam logic [CNT_W-1:0]   RP_LAST    = CNT_W'(RP_TICKS - 1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        IDLE    = 2'b00,
        ALERT   = 2'b01,
        PACE    = 2'b10,
        REFRACT = 2'b11
    } state_t;

    state_t             state_reg;
    logic [PRESC_W-1:0] presc_reg;
    logic [2:0]         sync_reg;
    logic [CNT_W-1:0]   esc_cnt_reg;
    logic [CNT_W-1:0]   ph_cnt_reg;
    logic [CNT_W-1:0]   lri_reg;
    logic [7:0]         pace_cnt_reg;

    logic               tick;
    logic               rise;
    logic [CNT_W-1:0]   lri_sel;
    logic [CNT_W-1:0]   lri_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            presc_reg <= '0;
        end else if (presc_reg == PRESC_LAST) begin
            presc_reg <= '0;
        end else begin
            presc_reg <= presc_reg + 1'b1;
        end
    end

    assign tick = (presc_reg == PRESC_LAST);

    // sync_reg[1] is the metastability-safe sample; sync_reg[2] delays it for edge detect
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_reg <= '0;
        end else begin
            sync_reg <= {sync_reg[1:0], sense_in};
        end
    end

    assign rise = sync_reg[1] & ~sync_reg[2];

    always_comb begin
        lri_sel = CNT_W'(LRI_0);
        case (rate_sel)
            2'd0: lri_sel = CNT_W'(LRI_0);
            2'd1: lri_sel = CNT_W'(LRI_1);
            2'd2: lri_sel = CNT_W'(LRI_2);
            2'd3: lri_sel = CNT_W'(LRI_3);
            default: lri_sel = CNT_W'(LRI_0);
        endcase
    end

    assign lri_last = lri_reg - CNT_W'(1);

    // Counter updates below the defaults override the per-tick increment on events
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg    <= IDLE;
            esc_cnt_reg  <= '0;
            ph_cnt_reg   <= '0;
            lri_reg      <= CNT_W'(LRI_0);
            pace_cnt_reg <= '0;
        end else begin
            if (tick && esc_cnt_reg != CNT_MAX) begin
                esc_cnt_reg <= esc_cnt_reg + 1'b1;
            end
            if (tick) begin
                ph_cnt_reg <= ph_cnt_reg + 1'b1;
            end

            if (!enable) begin
                state_reg <= IDLE;
            end else begin
                case (state_reg)
                    IDLE: begin
                        state_reg   <= ALERT;
                        esc_cnt_reg <= '0;
                        lri_reg     <= lri_sel;
                    end
                    ALERT: begin
                        // An intrinsic beat takes priority over a coincident escape expiry
                        if (rise) begin
                            state_reg   <= REFRACT;
                            esc_cnt_reg <= '0;
                            ph_cnt_reg  <= '0;
                            lri_reg     <= lri_sel;
                        end else if (tick && esc_cnt_reg == lri_last) begin
                            state_reg    <= PACE;
                            esc_cnt_reg  <= '0;
                            ph_cnt_reg   <= '0;
                            lri_reg      <= lri_sel;
                            pace_cnt_reg <= pace_cnt_reg + 1'b1;
                        end
                    end
                    PACE: begin
                        if (tick && ph_cnt_reg == PW_LAST) begin
                            state_reg  <= REFRACT;
                            ph_cnt_reg <= '0;
                        end
                    end
                    REFRACT: begin
                        if (tick && ph_cnt_reg == RP_LAST) begin
                            state_reg <= ALERT;
                        end
                    end
                    default: state_reg <= IDLE;
                endcase
            end
        end
    end

    assign state     = state_reg;
    assign pace_out  = (state_reg == PACE);
    assign sense_evt = (state_reg == ALERT) & enable & rise;
    assign pace_cnt  = pace_cnt_reg;

endmodule

// File: tb/tb_pacing_timing_controller.sv
// Directed bench for pacing_timing_controller with a shortened timebase
// (TICK_DIV=4, LRI=40/30/20/16 ticks, PW=2, RP=8).
module tb_pacing_timing_controller;

    localparam int TICK_DIV = 4;
    localparam int CNT_W    = 12;
    localparam int LRI_0    = 40;
    localparam int LRI_1    = 30;
    localparam int LRI_2    = 20;
    localparam int LRI_3    = 16;
    localparam int PW_TICKS = 2;
    localparam int RP_TICKS = 8;

    localparam logic [1:0] S_IDLE    = 2'b00;
    localparam logic [1:0] S_ALERT   = 2'b01;
    localparam logic [1:0] S_PACE    = 2'b10;
    localparam logic [1:0] S_REFRACT = 2'b11;

    logic       clk = 1'b0;
    logic       rst;
    logic       sense_in;
    logic       enable;
    logic [1:0] rate_sel;
    logic       pace_out;
    logic       sense_evt;
    logic [1:0] state;
    logic [7:0] pace_cnt;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    pacing_timing_controller #(
        .TICK_DIV (TICK_DIV),
        .CNT_W    (CNT_W),
        .LRI_0    (LRI_0),
        .LRI_1    (LRI_1),
        .LRI_2    (LRI_2),
        .LRI_3    (LRI_3),
        .PW_TICKS (PW_TICKS),
        .RP_TICKS (RP_TICKS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .sense_in  (sense_in),
        .enable    (enable),
        .rate_sel  (rate_sel),
        .pace_out  (pace_out),
        .sense_evt (sense_evt),
        .state     (state),
        .pace_cnt  (pace_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Wait for the next 0->1 transition of pace_out; t is the cycle it was first seen high.
    task automatic wait_rise(input int budget, output int t, output bit ok);
        bit seen0;
        seen0 = (pace_out === 1'b0);
        ok = 1'b0;
        t  = 0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (pace_out === 1'b0) begin
                seen0 = 1'b1;
            end else if (seen0 && pace_out === 1'b1) begin
                t  = cyc;
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        enable   = 1'b0;
        sense_in = 1'b0;
        rate_sel = 2'd0;
        step(2);
        rst = 1'b0;
        step(1);
    endtask

    task automatic test_reset();
        rst      = 1'b1;
        enable   = 1'b1;
        sense_in = 1'b0;
        rate_sel = 2'd0;
        step(3);
        vectors++;
        if (state !== S_IDLE) begin miscompares++; $display("FAIL reset_state: got %0d expected %0d", state, S_IDLE); end
        vectors++;
        if (pace_out !== 1'b0) begin miscompares++; $display("FAIL reset_pace_out: got %0b expected 0", pace_out); end
        vectors++;
        if (sense_evt !== 1'b0) begin miscompares++; $display("FAIL reset_sense_evt: got %0b expected 0", sense_evt); end
        vectors++;
        if (pace_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_pace_cnt: got %0d expected 0", pace_cnt); end
        rst = 1'b0;
        enable = 1'b0;
        step(1);
        $display("test_reset done");
    endtask

    task automatic test_escape();
        int a, t1, t0, t2;
        bit ok;
        do_reset();
        enable = 1'b1;
        step(1);
        a = cyc;
        vectors++;
        if (state !== S_ALERT) begin miscompares++; $display("FAIL esc_alert_entry: got %0d expected %0d", state, S_ALERT); end
        wait_rise(300, t1, ok);
        vectors++;
        if (!ok || (t1 - a) < 156 || (t1 - a) > 164) begin
            miscompares++; $display("FAIL esc_first_pace: got %0d clk (ok=%0b) expected 156..164", t1 - a, ok);
        end
        vectors++;
        if (pace_cnt !== 8'd1) begin miscompares++; $display("FAIL esc_cnt1: got %0d expected 1", pace_cnt); end
        vectors++;
        if (state !== S_PACE) begin miscompares++; $display("FAIL esc_state_pace: got %0d expected %0d", state, S_PACE); end
        ok = 1'b0;
        t0 = 0;
        for (int i = 0; i < 20; i++) begin
            step(1);
            if (pace_out === 1'b0) begin t0 = cyc; ok = 1'b1; break; end
        end
        vectors++;
        if (!ok || (t0 - t1) != 8) begin miscompares++; $display("FAIL esc_width: got %0d clk expected 8", t0 - t1); end
        vectors++;
        if (state !== S_REFRACT) begin miscompares++; $display("FAIL esc_post_refract: got %0d expected %0d", state, S_REFRACT); end
        wait_rise(300, t2, ok);
        vectors++;
        if (!ok || (t2 - t1) != 160) begin miscompares++; $display("FAIL esc_interval: got %0d clk expected 160", t2 - t1); end
        vectors++;
        if (pace_cnt !== 8'd2) begin miscompares++; $display("FAIL esc_cnt2: got %0d expected 2", pace_cnt); end
        $display("test_escape: first pace %0d clk after ALERT, interval %0d clk", t1 - a, t2 - t1);
    endtask

    task automatic test_sense_inhibit();
        int evt, lat, pc;
        do_reset();
        enable = 1'b1;
        step(3);
        for (int b = 0; b < 4; b++) begin
            sense_in = 1'b1;
            evt = 0;
            lat = -1;
            pc  = 0;
            for (int k = 1; k <= 100; k++) begin
                step(1);
                if (sense_evt === 1'b1) begin
                    evt++;
                    if (lat < 0) lat = k;
                end
                if (pace_out !== 1'b0) pc++;
                if (k == 4) sense_in = 1'b0;
            end
            vectors++;
            if (lat != 2) begin miscompares++; $display("FAIL sense_latency beat %0d: got %0d expected 2", b, lat); end
            vectors++;
            if (evt != 1) begin miscompares++; $display("FAIL sense_evt_count beat %0d: got %0d expected 1", b, evt); end
            vectors++;
            if (pc != 0) begin miscompares++; $display("FAIL sense_no_pace beat %0d: got %0d pace cycles expected 0", b, pc); end
            $display("test_sense_inhibit beat %0d: latency %0d, events %0d", b, lat, evt);
        end
        vectors++;
        if (pace_cnt !== 8'd0) begin miscompares++; $display("FAIL sense_pace_cnt: got %0d expected 0", pace_cnt); end
    endtask

    task automatic test_refractory();
        int t_evt, t, evt;
        bit ok, got;
        do_reset();
        enable = 1'b1;
        step(3);
        sense_in = 1'b1;
        got = 1'b0;
        t_evt = 0;
        for (int k = 0; k < 10; k++) begin
            step(1);
            if (sense_evt === 1'b1) begin t_evt = cyc; got = 1'b1; break; end
        end
        sense_in = 1'b0;
        vectors++;
        if (!got) begin miscompares++; $display("FAIL refr_first_evt: got none expected 1"); end
        step(12);
        sense_in = 1'b1;
        evt = 0;
        ok = 1'b0;
        t = 0;
        for (int k = 1; k <= 300; k++) begin
            step(1);
            if (k == 4) sense_in = 1'b0;
            if (sense_evt === 1'b1) evt++;
            if (pace_out === 1'b1) begin t = cyc; ok = 1'b1; break; end
        end
        vectors++;
        if (evt != 0) begin miscompares++; $display("FAIL refr_ignored: got %0d events expected 0", evt); end
        vectors++;
        if (!ok || (t - t_evt) < 156 || (t - t_evt) > 164) begin
            miscompares++; $display("FAIL refr_pace_time: got %0d clk (ok=%0b) expected 156..164", t - t_evt, ok);
        end
        $display("test_refractory: pace %0d clk after first beat, %0d refractory events", t - t_evt, evt);
    endtask

    task automatic test_rate_change();
        int t1, t2, t3, t4;
        bit ok1, ok2, ok3, ok4;
        do_reset();
        enable = 1'b1;
        wait_rise(300, t1, ok1);
        step(50);
        rate_sel = 2'd3;
        wait_rise(300, t2, ok2);
        wait_rise(300, t3, ok3);
        wait_rise(300, t4, ok4);
        vectors++;
        if (!ok1 || !ok2 || (t2 - t1) != 160) begin miscompares++; $display("FAIL rate_current: got %0d clk expected 160", t2 - t1); end
        vectors++;
        if (!ok3 || (t3 - t2) != 64) begin miscompares++; $display("FAIL rate_next1: got %0d clk expected 64", t3 - t2); end
        vectors++;
        if (!ok4 || (t4 - t3) != 64) begin miscompares++; $display("FAIL rate_next2: got %0d clk expected 64", t4 - t3); end
        $display("test_rate_change: intervals %0d %0d %0d clk", t2 - t1, t3 - t2, t4 - t3);
    endtask

    task automatic test_enable_drop();
        int t1, a, t2;
        bit ok;
        do_reset();
        enable = 1'b1;
        wait_rise(300, t1, ok);
        step(1);
        enable = 1'b0;
        step(1);
        vectors++;
        if (pace_out !== 1'b0) begin miscompares++; $display("FAIL en_pace_drop: got %0b expected 0", pace_out); end
        vectors++;
        if (state !== S_IDLE) begin miscompares++; $display("FAIL en_idle: got %0d expected %0d", state, S_IDLE); end
        vectors++;
        if (pace_cnt !== 8'd1) begin miscompares++; $display("FAIL en_truncated_count: got %0d expected 1", pace_cnt); end
        step(5);
        enable = 1'b1;
        step(1);
        a = cyc;
        wait_rise(300, t2, ok);
        vectors++;
        if (!ok || (t2 - a) < 156 || (t2 - a) > 164) begin
            miscompares++; $display("FAIL en_repace: got %0d clk (ok=%0b) expected 156..164", t2 - a, ok);
        end
        vectors++;
        if (pace_cnt !== 8'd2) begin miscompares++; $display("FAIL en_cnt2: got %0d expected 2", pace_cnt); end
        $display("test_enable_drop: re-pace %0d clk after re-enable", t2 - a);
    endtask

    task automatic test_coincidence();
        int p, t;
        bit ok;
        do_reset();
        enable = 1'b1;
        wait_rise(300, p, ok);
        // Next escape decision is the cycle observed at p+159; rise appears 2 cycles after drive
        step(157);
        sense_in = 1'b1;
        step(2);
        vectors++;
        if (sense_evt !== 1'b1) begin miscompares++; $display("FAIL coin_sense_evt: got %0b expected 1", sense_evt); end
        sense_in = 1'b0;
        step(1);
        vectors++;
        if (state !== S_REFRACT) begin miscompares++; $display("FAIL coin_state: got %0d expected %0d", state, S_REFRACT); end
        vectors++;
        if (pace_out !== 1'b0) begin miscompares++; $display("FAIL coin_no_pace: got %0b expected 0", pace_out); end
        vectors++;
        if (pace_cnt !== 8'd1) begin miscompares++; $display("FAIL coin_pace_cnt: got %0d expected 1", pace_cnt); end
        $display("test_coincidence: state %0d pace_cnt %0d", state, pace_cnt);
        wait_rise(300, t, ok);
        vectors++;
        if (!ok || pace_out !== 1'b1) begin miscompares++; $display("FAIL arst_setup: got pace_out %0b expected 1", pace_out); end
        #2;
        rst = 1'b1;
        #1;
        vectors++;
        if (pace_out !== 1'b0) begin miscompares++; $display("FAIL arst_pace_out: got %0b expected 0", pace_out); end
        vectors++;
        if (state !== S_IDLE) begin miscompares++; $display("FAIL arst_state: got %0d expected %0d", state, S_IDLE); end
        vectors++;
        if (pace_cnt !== 8'd0) begin miscompares++; $display("FAIL arst_pace_cnt: got %0d expected 0", pace_cnt); end
        step(1);
        rst = 1'b0;
        $display("test_async_reset: outputs cleared without a clock edge");
    endtask

    initial begin
        rst      = 1'b1;
        enable   = 1'b0;
        sense_in = 1'b0;
        rate_sel = 2'd0;
        test_reset();
        test_escape();
        test_sense_inhibit();
        test_refractory();
        test_rate_change();
        test_enable_drop();
        test_coincidence();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
